// File: rtl/fpga_io_pkg.sv
// Shared constants and types for the right-edge multi-pad IO tile.
package fpga_io_pkg;

  localparam int unsigned CFG_BITS   = 3;
  localparam int unsigned CFG_OUT_EN = 0;
  localparam int unsigned CFG_IN_EN  = 1;
  localparam int unsigned CFG_INV    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } ccff_state_e;

endpackage

// File: rtl/io_ccff_shadow_chain.sv
// Serial config chain with a shadow register that is copied to the live
// register only on a commit taken while the chain holds a complete image.
module io_ccff_shadow_chain
  import fpga_io_pkg::*;
#(
  parameter int unsigned N_PADS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ccff_head,
  input  logic                         ccff_en,
  input  logic                         ccff_commit,
  output logic                         ccff_tail,
  output logic                         cfg_valid,
  output logic                         cfg_err,
  output logic [N_PADS*CFG_BITS-1:0]   active_cfg
);

  localparam int unsigned CHAIN_LEN = N_PADS * CFG_BITS;
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CHAIN_LEN-1:0] active_q, active_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  ccff_state_e          state_q, state_d;
  logic                 tail_q, tail_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 commit_ok_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      tail_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      tail_q   <= tail_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    tail_d   = tail_q;
    valid_d  = valid_q;
    err_d    = err_q;

    // A commit racing a shift would copy a half-moved image, so it is refused.
    commit_ok_c = ccff_commit & ~ccff_en & (state_q == FULL);

    if (ccff_en) begin
      shadow_d = {shadow_q[CHAIN_LEN-2:0], ccff_head};
      tail_d   = shadow_q[CHAIN_LEN-1];
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (commit_ok_c) begin
      active_d = shadow_q;
      cnt_d    = '0;
      valid_d  = 1'b1;
      err_d    = 1'b0;
    end else if (ccff_commit) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE:    if (ccff_en) state_d = LOAD;
      LOAD:    if (cnt_d == CNT_MAX) state_d = FULL;
      FULL:    if (commit_ok_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ccff_tail  = tail_q;
  assign cfg_valid  = valid_q;
  assign cfg_err    = err_q;
  assign active_cfg = active_q;

endmodule

// File: rtl/grid_io_right_multi.sv
// Right-edge IO grid tile with N_PADS embedded pads, each gated by its own
// live config triple and by global isolation.
module grid_io_right_multi
  import fpga_io_pkg::*;
#(
  parameter int unsigned N_PADS = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              IO_ISOL_N,
  input  logic              ccff_head,
  input  logic              ccff_en,
  input  logic              ccff_commit,
  output logic              ccff_tail,
  output logic              cfg_valid,
  output logic              cfg_err,
  input  logic [N_PADS-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [N_PADS-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [N_PADS-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [N_PADS-1:0] left_pin_outpad,
  output logic [N_PADS-1:0] left_pin_inpad
);

  logic [N_PADS*CFG_BITS-1:0] active_cfg;
  logic                       gate_c;

  io_ccff_shadow_chain #(
    .N_PADS (N_PADS)
  ) u_chain (
    .clk         (prog_clk),
    .rst         (pReset),
    .ccff_head   (ccff_head),
    .ccff_en     (ccff_en),
    .ccff_commit (ccff_commit),
    .ccff_tail   (ccff_tail),
    .cfg_valid   (cfg_valid),
    .cfg_err     (cfg_err),
    .active_cfg  (active_cfg)
  );

  // Pads stay inert until a config is live and isolation is lifted.
  assign gate_c = IO_ISOL_N & cfg_valid;

  for (genvar i = 0; i < N_PADS; i++) begin : g_pad
    logic out_en_c;
    logic in_en_c;
    logic inv_c;

    assign out_en_c = active_cfg[CFG_BITS*i + CFG_OUT_EN];
    assign in_en_c  = active_cfg[CFG_BITS*i + CFG_IN_EN];
    assign inv_c    = active_cfg[CFG_BITS*i + CFG_INV];

    assign gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[i] = ~(out_en_c & gate_c);
    assign gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[i] = (left_pin_outpad[i] ^ inv_c) & out_en_c & gate_c;
    assign left_pin_inpad[i] = (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[i] ^ inv_c) & in_en_c & gate_c;
  end

endmodule
